// File: rtl/calc_pkg.sv
// Shared definitions for the arithmetic result path and its BCD conversion stage.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W     = 4;
  localparam int BCD_ADD3_THRESH = 5;

  // Result width of the nCr stage and the digit count needed to display it.
  localparam int CALC_BIN_W  = 12;
  localparam int CALC_DIGITS = 4;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_DIGIT_W'(BCD_ADD3_THRESH))
                 ? i_digit + BCD_DIGIT_W'(3)
                 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both sides.
// Optional leading-zero blanking mask on digit_blank when BCD_BLANK_EN is defined.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int BIN_W  = CALC_BIN_W,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]             digit_blank,
`endif
  output logic                          busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;

  logic [BCD_W-1:0]       w_bcd_corr;
  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [BCD_W-1:0]       w_shift_bcd;
  logic [BIN_W-1:0]       w_shift_bin;

  // All digits are corrected in parallel from their pre-correction values.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .i_digit (r_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_bcd_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The bit leaving the top digit is dropped by the fixed-width shift.
  assign w_shift     = {w_bcd_corr, r_bin} << 1;
  assign w_shift_bcd = w_shift[BCD_W+BIN_W-1 -: BCD_W];
  assign w_shift_bin = w_shift[BIN_W-1:0];

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank;

  // Scan from the most significant digit; digit 0 always stays visible.
  always_comb begin
    logic run_zero;
    w_blank  = '0;
    run_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run_zero   = run_zero & (w_shift_bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      w_blank[k] = run_zero;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      bcd_out   <= '0;
`ifdef BCD_BLANK_EN
      digit_blank <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin    <= bin_in;
            r_bcd    <= '0;
            r_cnt    <= CNT_W'(BIN_W);
            r_state  <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        SHIFT: begin
          r_bcd <= w_shift_bcd;
          r_bin <= w_shift_bin;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bcd_out   <= w_shift_bcd;
`ifdef BCD_BLANK_EN
            digit_blank <= w_blank;
`endif
          end
        end

        DONE: begin
          // A new request is not taken here; it waits for IDLE next cycle.
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
